// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one downstream memory port among p_num_clients requesters with
// round-robin arbitration. Every request that transfers downstream is tagged
// with a free slot index in its opaque field. A slot table remembers the
// owning client and the client's original opaque. Responses are steered back
// to their owner with the original opaque restored, so the memory may answer
// out of order.
//
// The MemIntf bundles are flattened into per-field ports:
//   clk, rst                 clock, synchronous active-high reset
//   client_req_val/rdy       per-client request handshake
//   client_req_opaque/addr/data
//                            per-client request message fields
//   client_resp_val/rdy      per-client response handshake
//   client_resp_opaque/data  response message, broadcast to every client
//   mem_req_*                shared downstream request port
//   mem_resp_*               shared downstream response port
//   in_flight                registered count of occupied slots
//
// Request and response paths are combinational pass-throughs. Only the
// priority pointer, the slot table and the in-flight count are registered.

// Simulation-only protocol checks for the arbiter's slot table.
module mem_port_arbiter_checker #(
    parameter int p_max_in_flight = 16,
    parameter int p_opaque_bits   = 8
) (
    input logic                               clk,
    input logic                               rst,
    input logic                               resp_val,
    input logic [$clog2(p_max_in_flight)-1:0] resp_idx,
    input logic [p_max_in_flight-1:0]         busy
);

    // The slot index must fit inside the opaque field.
    if (p_opaque_bits < $clog2(p_max_in_flight)) begin : g_opaque_width_check
        $error("mem_port_arbiter: p_opaque_bits too narrow for the slot index");
    end

    // A response must name a slot that is currently occupied.
    always @(posedge clk) begin
        if (!rst && resp_val) begin
            assert (busy[resp_idx])
            else $error("mem_port_arbiter: response for idle slot %0d", resp_idx);
        end
    end

endmodule

module mem_port_arbiter #(
    parameter int p_num_clients   = 2,
    parameter int p_max_in_flight = 16,
    parameter int p_opaque_bits   = 8,
    parameter int p_addr_bits     = 32,
    parameter int p_data_bits     = 32
) (
    input  logic                                        clk,
    input  logic                                        rst,

    input  logic [p_num_clients-1:0]                    client_req_val,
    output logic [p_num_clients-1:0]                    client_req_rdy,
    input  logic [p_num_clients-1:0][p_opaque_bits-1:0] client_req_opaque,
    input  logic [p_num_clients-1:0][p_addr_bits-1:0]   client_req_addr,
    input  logic [p_num_clients-1:0][p_data_bits-1:0]   client_req_data,
    output logic [p_num_clients-1:0]                    client_resp_val,
    input  logic [p_num_clients-1:0]                    client_resp_rdy,
    output logic [p_opaque_bits-1:0]                    client_resp_opaque,
    output logic [p_data_bits-1:0]                      client_resp_data,

    output logic                                        mem_req_val,
    input  logic                                        mem_req_rdy,
    output logic [p_opaque_bits-1:0]                    mem_req_opaque,
    output logic [p_addr_bits-1:0]                      mem_req_addr,
    output logic [p_data_bits-1:0]                      mem_req_data,
    input  logic                                        mem_resp_val,
    output logic                                        mem_resp_rdy,
    input  logic [p_opaque_bits-1:0]                    mem_resp_opaque,
    input  logic [p_data_bits-1:0]                      mem_resp_data,

    output logic [$clog2(p_max_in_flight):0]            in_flight
);

    localparam int c_idx_bits = $clog2(p_max_in_flight);
    localparam int c_id_bits  = (p_num_clients > 1) ? $clog2(p_num_clients) : 1;

    // Registered state
    logic [c_id_bits-1:0]     prio_r;
    logic [p_max_in_flight-1:0] busy_r;
    logic [c_id_bits-1:0]     owner_r       [p_max_in_flight];
    logic [p_opaque_bits-1:0] orig_opaque_r [p_max_in_flight];
    logic [c_idx_bits:0]      in_flight_r;

    // Combinational signals
    logic [p_num_clients-1:0]   grant_s;
    logic [c_id_bits-1:0]       grant_id_s;
    logic                       grant_found_s;
    int                         cand_s;
    logic [c_idx_bits-1:0]      alloc_idx_s;
    logic                       full_s;
    logic                       req_fire_s;
    logic [c_idx_bits-1:0]      resp_idx_s;
    logic [c_id_bits-1:0]       resp_owner_s;
    logic                       free_s;
    logic [p_max_in_flight-1:0] busy_nxt_s;
    logic [c_idx_bits:0]        in_flight_nxt_s;
    logic [c_id_bits-1:0]       prio_nxt_s;
    logic                       unused_opaque_s;

    // Round-robin scan starting at prio_r; independent of any ready signal.
    always_comb begin
        grant_s       = '0;
        grant_id_s    = '0;
        grant_found_s = 1'b0;
        cand_s        = 0;
        for (int i = 0; i < p_num_clients; i++) begin
            cand_s = (int'(prio_r) + i) % p_num_clients;
            if (!grant_found_s && client_req_val[cand_s]) begin
                grant_found_s  = 1'b1;
                grant_s[cand_s] = 1'b1;
                grant_id_s     = c_id_bits'(cand_s);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Lowest free slot, taken from the start-of-cycle occupancy only, so a
    // slot freed this cycle is not handed out until the next one.
    always_comb begin
        alloc_idx_s = '0;
        for (int i = p_max_in_flight - 1; i >= 0; i--) begin
            if (!busy_r[i]) begin
                alloc_idx_s = c_idx_bits'(i);
            end else begin
                alloc_idx_s = alloc_idx_s;
            end
        end
    end

    assign full_s         = &busy_r;
    assign mem_req_val    = grant_found_s & ~full_s;
    assign mem_req_opaque = p_opaque_bits'(alloc_idx_s);
    assign mem_req_addr   = client_req_addr[grant_id_s];
    assign mem_req_data   = client_req_data[grant_id_s];
    assign client_req_rdy = grant_s & {p_num_clients{mem_req_rdy & ~full_s}};
    assign req_fire_s     = mem_req_val & mem_req_rdy;

    // Response steering: the low opaque bits name the slot; the slot names
    // the owner. Upper opaque bits are don't-care and only feed the sink.
    assign resp_idx_s         = mem_resp_opaque[c_idx_bits-1:0];
    assign resp_owner_s       = owner_r[resp_idx_s];
    assign client_resp_opaque = orig_opaque_r[resp_idx_s];
    assign client_resp_data   = mem_resp_data;
    assign unused_opaque_s    = ^mem_resp_opaque;

    // Per-client response valid and backpressure from the owning client.
    always_comb begin
        client_resp_val = '0;
        for (int k = 0; k < p_num_clients; k++) begin
            client_resp_val[k] = mem_resp_val & (resp_owner_s == c_id_bits'(k));
        end
        if (int'(resp_owner_s) < p_num_clients) begin
            mem_resp_rdy = client_resp_rdy[resp_owner_s];
        end else begin
            mem_resp_rdy = 1'b0;
        end
    end

    // Only a transfer on an occupied slot counts as a free.
    assign free_s = mem_resp_val & mem_resp_rdy & busy_r[resp_idx_s];

    // Next occupancy, count and priority pointer.
    always_comb begin
        busy_nxt_s = busy_r;
        if (free_s) begin
            busy_nxt_s[resp_idx_s] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (req_fire_s) begin
            busy_nxt_s[alloc_idx_s] = 1'b1;
            if (grant_id_s == c_id_bits'(p_num_clients - 1)) begin
                prio_nxt_s = '0;
            end else begin
                prio_nxt_s = grant_id_s + c_id_bits'(1);
            end
        end else begin
            prio_nxt_s = prio_r;
        end
        case ({req_fire_s, free_s})
            2'b10:   in_flight_nxt_s = in_flight_r + (c_idx_bits + 1)'(1);
            2'b01:   in_flight_nxt_s = in_flight_r - (c_idx_bits + 1)'(1);
            default: in_flight_nxt_s = in_flight_r;
        endcase
    end

    // State registers and slot-table writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_r      <= '0;
            busy_r      <= '0;
            in_flight_r <= '0;
            for (int i = 0; i < p_max_in_flight; i++) begin
                owner_r[i]       <= '0;
                orig_opaque_r[i] <= '0;
            end
        end else begin
            prio_r      <= prio_nxt_s;
            busy_r      <= busy_nxt_s;
            in_flight_r <= in_flight_nxt_s;
            if (req_fire_s) begin
                owner_r[alloc_idx_s]       <= grant_id_s;
                orig_opaque_r[alloc_idx_s] <= client_req_opaque[grant_id_s];
            end
        end
    end

    assign in_flight = in_flight_r;

    mem_port_arbiter_checker #(
        .p_max_in_flight (p_max_in_flight),
        .p_opaque_bits   (p_opaque_bits)
    ) u_checker (
        .clk      (clk),
        .rst      (rst),
        .resp_val (mem_resp_val),
        .resp_idx (resp_idx_s),
        .busy     (busy_r)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. A slot-table reference model (arrays
// of occupancy, owner and original opaque plus a priority pointer) predicts
// every port each cycle; all comparisons go through check_value.
module tb_mem_port_arbiter;

    localparam int N    = 2;
    localparam int MAXF = 16;
    localparam int OB   = 8;
    localparam int IW   = 4;
    localparam int AB   = 32;
    localparam int DB   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]         client_req_val;
    logic [N-1:0]         client_req_rdy;
    logic [N-1:0][OB-1:0] client_req_opaque;
    logic [N-1:0][AB-1:0] client_req_addr;
    logic [N-1:0][DB-1:0] client_req_data;
    logic [N-1:0]         client_resp_val;
    logic [N-1:0]         client_resp_rdy;
    logic [OB-1:0]        client_resp_opaque;
    logic [DB-1:0]        client_resp_data;
    logic                 mem_req_val;
    logic                 mem_req_rdy;
    logic [OB-1:0]        mem_req_opaque;
    logic [AB-1:0]        mem_req_addr;
    logic [DB-1:0]        mem_req_data;
    logic                 mem_resp_val;
    logic                 mem_resp_rdy;
    logic [OB-1:0]        mem_resp_opaque;
    logic [DB-1:0]        mem_resp_data;
    logic [IW:0]          in_flight;

    mem_port_arbiter #(
        .p_num_clients   (N),
        .p_max_in_flight (MAXF),
        .p_opaque_bits   (OB),
        .p_addr_bits     (AB),
        .p_data_bits     (DB)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .client_req_val     (client_req_val),
        .client_req_rdy     (client_req_rdy),
        .client_req_opaque  (client_req_opaque),
        .client_req_addr    (client_req_addr),
        .client_req_data    (client_req_data),
        .client_resp_val    (client_resp_val),
        .client_resp_rdy    (client_resp_rdy),
        .client_resp_opaque (client_resp_opaque),
        .client_resp_data   (client_resp_data),
        .mem_req_val        (mem_req_val),
        .mem_req_rdy        (mem_req_rdy),
        .mem_req_opaque     (mem_req_opaque),
        .mem_req_addr       (mem_req_addr),
        .mem_req_data       (mem_req_data),
        .mem_resp_val       (mem_resp_val),
        .mem_resp_rdy       (mem_resp_rdy),
        .mem_resp_opaque    (mem_resp_opaque),
        .mem_resp_data      (mem_resp_data),
        .in_flight          (in_flight)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit            m_busy  [MAXF];
    int            m_owner [MAXF];
    logic [OB-1:0] m_opq   [MAXF];
    int            m_prio;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < MAXF; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < MAXF; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    task automatic drive_idle();
        client_req_val    = '0;
        client_req_opaque = '0;
        client_req_addr   = '0;
        client_req_data   = '0;
        client_resp_rdy   = '0;
        mem_req_rdy       = 1'b0;
        mem_resp_val      = 1'b0;
        mem_resp_opaque   = '0;
        mem_resp_data     = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        for (int i = 0; i < MAXF; i++) begin
            m_busy[i]  = 1'b0;
            m_owner[i] = 0;
            m_opq[i]   = '0;
        end
        m_prio = 0;
        rst = 1'b0;
    endtask

    // One cycle: random inputs (percent probabilities), predict, compare, update model.
    task automatic run_cycle(input int p_req, input int p_resp, input int p_mrdy, input int p_crdy);
        int            g;
        int            c;
        int            ff;
        int            ridx;
        int            nth;
        int            own;
        bit            full;
        bit            exp_req_val;
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  exp_rval;
        logic [OB-1:0] tmp;

        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            client_req_val[k]    = ($urandom_range(99) < p_req);
            client_req_opaque[k] = OB'($urandom);
            client_req_addr[k]   = AB'($urandom);
            client_req_data[k]   = DB'($urandom);
            client_resp_rdy[k]   = ($urandom_range(99) < p_crdy);
        end
        mem_req_rdy   = ($urandom_range(99) < p_mrdy);
        mem_resp_data = DB'($urandom);
        ridx = 0;
        if (busy_count() > 0 && $urandom_range(99) < p_resp) begin
            nth = $urandom_range(busy_count() - 1);
            for (int i = 0; i < MAXF; i++) begin
                if (m_busy[i]) begin
                    if (nth == 0) ridx = i;
                    nth--;
                end
            end
            tmp = OB'($urandom);
            tmp[IW-1:0] = IW'(ridx);
            mem_resp_opaque = tmp;
            mem_resp_val    = 1'b1;
        end else begin
            mem_resp_opaque = OB'($urandom);
            mem_resp_val    = 1'b0;
        end
        #1;

        // Prediction from the slot-table rules
        full = (busy_count() == MAXF);
        g = -1;
        for (int k = 0; k < N; k++) begin
            c = (m_prio + k) % N;
            if (g < 0 && client_req_val[c]) g = c;
        end
        ff = first_free();
        exp_req_val = (g >= 0) && !full;
        exp_rdy = '0;
        if (g >= 0 && mem_req_rdy && !full) exp_rdy[g] = 1'b1;

        check_value("in_flight", 64'(in_flight), 64'(busy_count()));
        check_value("mem_req_val", 64'(mem_req_val), 64'(exp_req_val));
        check_value("client_req_rdy", 64'(client_req_rdy), 64'(exp_rdy));
        if (exp_req_val) begin
            check_value("mem_req_opaque", 64'(mem_req_opaque), 64'(ff));
            check_value("mem_req_addr", 64'(mem_req_addr), 64'(client_req_addr[g]));
            check_value("mem_req_data", 64'(mem_req_data), 64'(client_req_data[g]));
        end
        exp_rval = '0;
        if (mem_resp_val) begin
            own = m_owner[ridx];
            exp_rval[own] = 1'b1;
            check_value("mem_resp_rdy", 64'(mem_resp_rdy), 64'(client_resp_rdy[own]));
            check_value("client_resp_opaque", 64'(client_resp_opaque), 64'(m_opq[ridx]));
            check_value("client_resp_data", 64'(client_resp_data), 64'(mem_resp_data));
        end
        check_value("client_resp_val", 64'(client_resp_val), 64'(exp_rval));

        @(posedge clk);
        // Allocation uses the start-of-cycle table; the freed slot is a different, busy one.
        if (exp_req_val && mem_req_rdy) begin
            m_busy[ff]  = 1'b1;
            m_owner[ff] = g;
            m_opq[ff]   = client_req_opaque[g];
            m_prio      = (g + 1) % N;
        end
        if (mem_resp_val && client_resp_rdy[m_owner[ridx]]) begin
            m_busy[ridx] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        do_reset();
        repeat (3)   run_cycle(0, 0, 100, 100);      // reset defaults, idle clients
        repeat (6)   run_cycle(100, 0, 100, 100);    // round-robin alternation
        repeat (20)  run_cycle(100, 0, 100, 100);    // fill the table, then full
        repeat (3)   run_cycle(100, 0, 0, 100);      // stalled downstream at full
        repeat (40)  run_cycle(100, 25, 100, 100);   // frees racing allocations at full
        repeat (80)  run_cycle(60, 50, 50, 40);      // mixed traffic with backpressure
        do_reset();                                   // reset with slots outstanding
        repeat (2)   run_cycle(0, 0, 100, 100);
        repeat (250) run_cycle(50, 40, 70, 60);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
